tracker_activity_sequencer: RTL and testbench

Controller for the step-tracker datapath, running in the step_clk domain. It measures steps per one-second window and runs the first-nine-seconds ">32 steps/sec" evaluation. It accumulates high-activity time and sequences the 4-mode display rotation that selects which datapath BCD group drives the seven-segment display. step_pulse and sec_tick arrive as single-cycle strobes already synchronous to step_clk.

---
 rtl/tracker_pkg.sv | 18 +
 rtl/tracker_sec_window.sv | 34 +++
 rtl/tracker_activity_sequencer.sv | 135 +++++++++++++
 tb/tb_tracker_activity_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared encodings and limits for the step-tracker activity sequencer.
package tracker_pkg;

  typedef enum logic [1:0] {
    MODE_STEPS  = 2'd0,
    MODE_DIST   = 2'd1,
    MODE_OVER32 = 2'd2,
    MODE_HIACT  = 2'd3
  } mode_e;

  typedef enum logic {
    W_RUN  = 1'b0,
    W_DONE = 1'b1
  } win_state_e;

  localparam int HI_ACT_MAX = 9999;

endpackage

// File: rtl/tracker_sec_window.sv
// Saturating live step counter; presents the closing second's sample on sec_tick.
module tracker_sec_window
  import tracker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             step_clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             sec_tick,
  output logic [CNT_W-1:0] sample,
  output logic             sample_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] live_cnt;

  // A pulse coincident with the tick is folded into the closing second.
  always_comb begin
    sample = live_cnt;
    if (step_pulse && (live_cnt != CNT_MAX)) sample = live_cnt + CNT_ONE;
  end

  assign sample_vld = sec_tick;

  always_ff @(posedge step_clk or posedge reset) begin
    if (reset) live_cnt <= '0;
    else if (sec_tick) live_cnt <= '0;
    else live_cnt <= sample;
  end

endmodule

// File: rtl/tracker_activity_sequencer.sv
// Step-tracker controller: per-second sampling, nine-second evaluation window,
// high-activity crediting and display-mode rotation.
module tracker_activity_sequencer
  import tracker_pkg::*;
#(
  parameter int ROT_SECS    = 2,
  parameter int OVER_THRESH = 32,
  parameter int HI_THRESH   = 64,
  parameter int HI_MIN_RUN  = 60,
  parameter int WIN_SECS    = 9,
  parameter int CNT_W       = 8
) (
  input  logic             step_clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             sec_tick,
  input  logic             mode_hold,
  output logic [1:0]       mode,
  output logic             mode_adv,
  output logic [CNT_W-1:0] sec_count,
  output logic [3:0]       over32_count,
  output logic             win_done,
  output logic [13:0]      hi_act_secs
);

  localparam int IDX_W = $clog2(WIN_SECS + 1);
  localparam int RUN_W = $clog2(HI_MIN_RUN + 1);
  localparam int ROT_W = $clog2(ROT_SECS + 1);

  localparam logic [CNT_W-1:0] OVER_T   = CNT_W'(OVER_THRESH);
  localparam logic [CNT_W-1:0] HI_T     = CNT_W'(HI_THRESH);
  localparam logic [IDX_W-1:0] WIN_END  = IDX_W'(WIN_SECS);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(HI_MIN_RUN);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(HI_MIN_RUN - 1);
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_SECS - 1);

  logic [CNT_W-1:0] sample;
  logic             sample_vld;

  tracker_sec_window #(.CNT_W(CNT_W)) u_sec_window (
    .step_clk   (step_clk),
    .reset      (reset),
    .step_pulse (step_pulse),
    .sec_tick   (sec_tick),
    .sample     (sample),
    .sample_vld (sample_vld)
  );

  win_state_e       win_state, win_state_n;
  logic [IDX_W-1:0] win_idx, win_idx_n;
  logic [3:0]       over32_n;
  logic [RUN_W-1:0] run_len, run_len_n;
  logic [13:0]      hi_add, hi_n;
  logic [14:0]      hi_sum;
  logic [ROT_W-1:0] rot_cnt, rot_cnt_n;
  logic [1:0]       mode_n;
  logic             mode_adv_n;
  logic [CNT_W-1:0] sec_count_n;

  always_comb begin
    win_state_n = win_state;
    win_idx_n   = win_idx;
    over32_n    = over32_count;
    run_len_n   = run_len;
    hi_add      = '0;
    rot_cnt_n   = rot_cnt;
    mode_n      = mode;
    mode_adv_n  = 1'b0;
    sec_count_n = sec_count;

    if (sample_vld) begin
      sec_count_n = sample;

      if (win_state == W_RUN) begin
        if (sample > OVER_T) over32_n = over32_count + 4'd1;
        win_idx_n = win_idx + 1'b1;
        if (win_idx_n == WIN_END) win_state_n = W_DONE;
      end

      // Credit lands in one lump when the run first qualifies, then per second.
      if (sample >= HI_T) begin
        if (run_len == RUN_LAST) begin
          run_len_n = RUN_MAX;
          hi_add    = 14'(HI_MIN_RUN);
        end else if (run_len == RUN_MAX) begin
          hi_add = 14'd1;
        end else begin
          run_len_n = run_len + 1'b1;
        end
      end else begin
        run_len_n = '0;
      end

      if (!mode_hold) begin
        if (rot_cnt == ROT_LAST) begin
          rot_cnt_n  = '0;
          mode_n     = mode + 2'd1;
          mode_adv_n = 1'b1;
        end else begin
          rot_cnt_n = rot_cnt + 1'b1;
        end
      end
    end

    hi_sum = {1'b0, hi_act_secs} + {1'b0, hi_add};
    hi_n   = (hi_sum > 15'(HI_ACT_MAX)) ? 14'(HI_ACT_MAX) : hi_sum[13:0];
  end

  always_ff @(posedge step_clk or posedge reset) begin
    if (reset) begin
      win_state    <= W_RUN;
      win_idx      <= '0;
      over32_count <= '0;
      run_len      <= '0;
      hi_act_secs  <= '0;
      rot_cnt      <= '0;
      mode         <= MODE_STEPS;
      mode_adv     <= 1'b0;
      sec_count    <= '0;
    end else begin
      win_state    <= win_state_n;
      win_idx      <= win_idx_n;
      over32_count <= over32_n;
      run_len      <= run_len_n;
      hi_act_secs  <= hi_n;
      rot_cnt      <= rot_cnt_n;
      mode         <= mode_n;
      mode_adv     <= mode_adv_n;
      sec_count    <= sec_count_n;
    end
  end

  assign win_done = (win_state == W_DONE);

endmodule

// File: tb/tb_tracker_activity_sequencer.sv
// Scoreboard bench for tracker_activity_sequencer with a per-second reference model.
module tb_tracker_activity_sequencer;

  localparam int EXP_W = 30;

  logic        step_clk;
  logic        reset;
  logic        step_pulse;
  logic        sec_tick;
  logic        mode_hold;
  logic [1:0]  mode;
  logic        mode_adv;
  logic [7:0]  sec_count;
  logic [3:0]  over32_count;
  logic        win_done;
  logic [13:0] hi_act_secs;

  tracker_activity_sequencer dut (
    .step_clk     (step_clk),
    .reset        (reset),
    .step_pulse   (step_pulse),
    .sec_tick     (sec_tick),
    .mode_hold    (mode_hold),
    .mode         (mode),
    .mode_adv     (mode_adv),
    .sec_count    (sec_count),
    .over32_count (over32_count),
    .win_done     (win_done),
    .hi_act_secs  (hi_act_secs)
  );

  // Clock / reset
  initial step_clk = 1'b0;
  always #5 step_clk = ~step_clk;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic tick_d = 1'b0;

  // Reference model state, all in whole seconds since the last reset
  int m_secs, m_over, m_run, m_hi, m_rot;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_secs = 0; m_over = 0; m_run = 0; m_hi = 0; m_rot = 0;
  endtask

  function automatic logic [EXP_W-1:0] model_second(input int steps, input bit hold);
    int smp;
    bit adv;
    smp = (steps > 255) ? 255 : steps;
    m_secs++;
    if (m_secs <= 9 && smp > 32) m_over++;
    if (smp >= 64) m_run++;
    else m_run = 0;
    if (m_run == 60) m_hi += 60;
    else if (m_run > 60) m_hi += 1;
    if (m_hi > 9999) m_hi = 9999;
    adv = 1'b0;
    if (!hold) begin
      m_rot++;
      adv = (m_rot % 2 == 0);
    end
    return {8'(smp), 4'(m_over), (m_secs >= 9), 14'(m_hi), 2'((m_rot / 2) % 4), adv};
  endfunction

  // Driver tasks: inputs change just after the falling edge
  task automatic cycle(input bit sp, input bit st);
    step_pulse = sp;
    sec_tick   = st;
    @(negedge step_clk);
  endtask

  task automatic one_second(input int steps, input bit hold, input bit coinc);
    int pulses;
    mode_hold = hold;
    pulses = (coinc && steps > 0) ? steps - 1 : steps;
    for (int i = 0; i < pulses; i++) begin
      cycle(1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 1'b0);
    end
    exp_q.push_back(model_second(steps, hold));
    cycle(coinc && steps > 0, 1'b1);
    step_pulse = 1'b0;
    sec_tick   = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge step_clk);
    #2 reset = 1'b1;
    #1;
    check({tag, "_mode"}, mode, 0);
    check({tag, "_mode_adv"}, mode_adv, 0);
    check({tag, "_sec_count"}, sec_count, 0);
    check({tag, "_over32"}, over32_count, 0);
    check({tag, "_win_done"}, win_done, 0);
    check({tag, "_hi_act"}, hi_act_secs, 0);
    exp_q.delete();
    model_clear();
    @(negedge step_clk);
    #2 reset = 1'b0;
  endtask

  // Monitor: the cycle after a sampled tick carries that second's results
  always @(posedge step_clk) tick_d <= sec_tick && !reset;

  always @(negedge step_clk) begin
    logic [EXP_W-1:0] e;
    if (tick_d) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sec_count", sec_count, e[29:22]);
        check("over32_count", over32_count, e[21:18]);
        check("win_done", win_done, e[17]);
        check("hi_act_secs", hi_act_secs, e[16:3]);
        check("mode", mode, e[2:1]);
        check("mode_adv", mode_adv, e[0]);
      end
    end else if (!reset) begin
      check("mode_adv_idle", mode_adv, 0);
    end
  end

  initial begin
    int wseq[10] = '{33, 32, 40, 0, 50, 33, 10, 100, 31, 99};
    int mseq[5]  = '{40, 10, 50, 60, 5};
    reset = 1'b1; step_pulse = 1'b0; sec_tick = 1'b0; mode_hold = 1'b0;
    model_clear();
    repeat (3) @(negedge step_clk);

    do_reset("rst0");
    repeat (4) one_second(0, 1'b0, 1'b0);

    do_reset("rst_win");
    foreach (wseq[i]) one_second(wseq[i], 1'b0, 1'b0);

    do_reset("rst_coinc");
    one_second(33, 1'b0, 1'b1);
    one_second(0, 1'b0, 1'b0);
    one_second(5, 1'b0, 1'b1);

    do_reset("rst_hold");
    repeat (2) one_second(3, 1'b0, 1'b0);
    repeat (5) one_second(40, 1'b1, 1'b0);
    repeat (2) one_second(1, 1'b0, 1'b0);

    do_reset("rst_hi");
    repeat (61) one_second(64, 1'b0, 1'b0);
    one_second(63, 1'b0, 1'b0);
    do_reset("rst_hi59");
    repeat (59) one_second(64, 1'b0, 1'b0);
    one_second(0, 1'b0, 1'b0);

    do_reset("rst_mid");
    foreach (mseq[i]) one_second(mseq[i], 1'b0, 1'b0);
    do_reset("rst_midchk");
    repeat (3) one_second(45, 1'b0, 1'b0);

    do_reset("rst_rand");
    for (int i = 0; i < 30; i++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 90);
      one_second(s, $urandom_range(0, 3) == 0, $urandom_range(0, 1));
    end

    repeat (4) @(negedge step_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
